// File: rtl/lane_sel_pkg.sv
// Shared constants and helpers for the lane selector pipeline.
package lane_sel_pkg;

  // Default geometry of the selector.
  localparam int LANE_W_DEF    = 4;
  localparam int IN_LANES_DEF  = 8;
  localparam int OUT_LANES_DEF = 4;
  localparam int CNT_W_DEF     = 16;

  // Values of one CFG_SEL bit: which source word feeds an output lane.
  localparam logic SEL_SRC_A = 1'b0;
  localparam logic SEL_SRC_B = 1'b1;

  // Width of a lane index field; never narrower than one bit so a
  // single-lane input still has a legal field.
  function automatic int idx_width(input int n_lanes);
    if (n_lanes <= 2) begin
      return 1;
    end
    return $clog2(n_lanes);
  endfunction

endpackage

// File: rtl/lane_sel_fifo2.sv
// Two-entry circular buffer with valid/ready on both sides.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that side. o_ready depends only on the stored count, never
// on i_ready, so the upstream ready has no combinational path from
// downstream. Once o_valid is high, o_valid and o_data hold until the
// entry is taken. o_data is registered and keeps its last value while
// the buffer is empty.
module lane_sel_fifo2
  import lane_sel_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_dout;

  logic             w_push;
  logic             w_pop;
  logic             w_rd_ptr_nxt;
  logic [1:0]       w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_push       = i_valid && (r_count != 2'd2);
  assign w_pop        = i_ready && (r_count != 2'd0);
  assign w_rd_ptr_nxt = r_rd_ptr ^ w_pop;

  // Occupancy after this edge; push+pop together leaves it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Head after this edge: the entry being written now if it lands in
  // the slot the read pointer will point at, otherwise stored data.
  always_comb begin
    w_head_nxt = r_mem[w_rd_ptr_nxt];
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_nxt = i_data;
    end
  end

  // Storage, pointers, count and registered head.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_dout   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      if (w_count_nxt != 2'd0) begin
        r_dout <= w_head_nxt;
      end
    end
  end

  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_dout;

endmodule

// File: rtl/lane_selector_pipe.sv
// Configurable lane selector: each output lane picks one lane from DATA_A
// or DATA_B through registered config, with per-lane zero masking, a
// two-entry output buffer and a count of delivered beats.
module lane_selector_pipe
  import lane_sel_pkg::*;
#(
  parameter int LANE_W    = LANE_W_DEF,
  parameter int IN_LANES  = IN_LANES_DEF,
  parameter int OUT_LANES = OUT_LANES_DEF,
  parameter int IDX_W     = idx_width(IN_LANES),
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        CFG_WE,
  input  logic [OUT_LANES*IDX_W-1:0]  CFG_SEL_A,
  input  logic [OUT_LANES*IDX_W-1:0]  CFG_SEL_B,
  input  logic [OUT_LANES-1:0]        CFG_SEL,
  input  logic [OUT_LANES-1:0]        CFG_LANE_EN,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  input  logic [IN_LANES*LANE_W-1:0]  DATA_A,
  input  logic [IN_LANES*LANE_W-1:0]  DATA_B,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic [OUT_LANES*LANE_W-1:0] OUT_DATA,
  output logic [CNT_W-1:0]            BEAT_CNT
);

  logic [OUT_LANES*IDX_W-1:0]  r_sel_a;
  logic [OUT_LANES*IDX_W-1:0]  r_sel_b;
  logic [OUT_LANES-1:0]        r_sel;
  logic [OUT_LANES-1:0]        r_lane_en;
  logic [CNT_W-1:0]            r_beat_cnt;

  logic [OUT_LANES*LANE_W-1:0] w_sel_word;
  logic                        w_in_ready;
  logic                        w_out_valid;
  logic                        w_out_fire;

  // Config registers; a beat accepted on the same edge as CFG_WE still
  // sees the old values because the mux reads only these registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sel_a   <= '0;
      r_sel_b   <= '0;
      r_sel     <= '0;
      r_lane_en <= '0;
    end else if (CFG_WE) begin
      r_sel_a   <= CFG_SEL_A;
      r_sel_b   <= CFG_SEL_B;
      r_sel     <= CFG_SEL;
      r_lane_en <= CFG_LANE_EN;
    end
  end

  // One mux per output lane. The index is compared against every real
  // input lane, so an index past the last lane matches nothing and the
  // lane reads zero.
  for (genvar k = 0; k < OUT_LANES; k++) begin : g_lane
    logic                       w_use_b;
    logic [IDX_W-1:0]           w_idx;
    logic [IN_LANES*LANE_W-1:0] w_src;
    logic [LANE_W-1:0]          w_lane;

    assign w_use_b = (r_sel[k] == SEL_SRC_B);
    assign w_idx   = w_use_b ? r_sel_b[k*IDX_W +: IDX_W]
                             : r_sel_a[k*IDX_W +: IDX_W];
    assign w_src   = w_use_b ? DATA_B : DATA_A;

    // Pick the indexed lane of the chosen source, or zero if masked.
    always_comb begin
      w_lane = '0;
      if (r_lane_en[k]) begin
        for (int j = 0; j < IN_LANES; j++) begin
          if (w_idx == IDX_W'(j)) begin
            w_lane = w_src[j*LANE_W +: LANE_W];
          end
        end
      end
    end

    assign w_sel_word[k*LANE_W +: LANE_W] = w_lane;
  end

  lane_sel_fifo2 #(
    .WIDTH (OUT_LANES*LANE_W)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_valid (IN_VALID),
    .o_ready (w_in_ready),
    .i_data  (w_sel_word),
    .o_valid (w_out_valid),
    .i_ready (OUT_READY),
    .o_data  (OUT_DATA)
  );

  assign w_out_fire = w_out_valid && OUT_READY;

  // Delivered-beat counter; wraps naturally at its width.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_beat_cnt <= '0;
    end else if (w_out_fire) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  assign IN_READY  = w_in_ready;
  assign OUT_VALID = w_out_valid;
  assign BEAT_CNT  = r_beat_cnt;

endmodule

// File: tb/tb_lane_selector_pipe.sv
// Bench for lane_selector_pipe: a default instance and a second one with
// six input lanes and a 4-bit beat counter share the same stimulus.
module tb_lane_selector_pipe;

  logic        CLK;
  logic        RESET;
  logic        CFG_WE;
  logic [11:0] CFG_SEL_A;
  logic [11:0] CFG_SEL_B;
  logic [3:0]  CFG_SEL;
  logic [3:0]  CFG_LANE_EN;
  logic        IN_VALID;
  logic [31:0] DATA_A;
  logic [31:0] DATA_B;
  logic        OUT_READY;

  logic        in_ready1, out_valid1;
  logic [15:0] out_data1;
  logic [15:0] beat_cnt1;
  logic        in_ready2, out_valid2;
  logic [15:0] out_data2;
  logic [3:0]  beat_cnt2;

  lane_selector_pipe dut1 (
    .CLK(CLK), .RESET(RESET), .CFG_WE(CFG_WE),
    .CFG_SEL_A(CFG_SEL_A), .CFG_SEL_B(CFG_SEL_B),
    .CFG_SEL(CFG_SEL), .CFG_LANE_EN(CFG_LANE_EN),
    .IN_VALID(IN_VALID), .IN_READY(in_ready1),
    .DATA_A(DATA_A), .DATA_B(DATA_B),
    .OUT_VALID(out_valid1), .OUT_READY(OUT_READY),
    .OUT_DATA(out_data1), .BEAT_CNT(beat_cnt1)
  );

  lane_selector_pipe #(.IN_LANES(6), .CNT_W(4)) dut2 (
    .CLK(CLK), .RESET(RESET), .CFG_WE(CFG_WE),
    .CFG_SEL_A(CFG_SEL_A), .CFG_SEL_B(CFG_SEL_B),
    .CFG_SEL(CFG_SEL), .CFG_LANE_EN(CFG_LANE_EN),
    .IN_VALID(IN_VALID), .IN_READY(in_ready2),
    .DATA_A(DATA_A[23:0]), .DATA_B(DATA_B[23:0]),
    .OUT_VALID(out_valid2), .OUT_READY(OUT_READY),
    .OUT_DATA(out_data2), .BEAT_CNT(beat_cnt2)
  );

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Output lane k: the idx-th nibble of the chosen source, zero when the
  // lane is disabled or idx names a lane the input does not have.
  function automatic logic [15:0] ref_sel(input logic [31:0] a, input logic [31:0] b,
                                          input logic [11:0] sa, input logic [11:0] sb,
                                          input logic [3:0] sel, input logic [3:0] en,
                                          input int n_lanes);
    logic [15:0] r;
    r = 16'h0;
    for (int k = 0; k < 4; k++) begin
      int idx;
      logic [31:0] src;
      idx = sel[k] ? int'((sb >> (3*k)) & 12'd7) : int'((sa >> (3*k)) & 12'd7);
      src = sel[k] ? b : a;
      if (en[k] && idx < n_lanes) begin
        r[k*4 +: 4] = 4'((src >> (4*idx)) & 32'hF);
      end
    end
    return r;
  endfunction

  logic [15:0] exp_q[$];
  logic [15:0] exp2_q[$];
  logic [11:0] m_sa, m_sb;
  logic [3:0]  m_sel, m_en;
  int          exp_cnt = 0;
  bit          model_ok = 0;
  bit          just_reset = 0;

  // ---------------- monitor / scoreboard ----------------
  // Sampled mid-cycle: outputs reflect the last edge, inputs are what the
  // next edge will see.
  always @(negedge CLK) begin
    if (model_ok) begin
      chk("in_ready1",  {31'b0, in_ready1},  {31'b0, exp_q.size() < 2});
      chk("in_ready2",  {31'b0, in_ready2},  {31'b0, exp_q.size() < 2});
      chk("out_valid1", {31'b0, out_valid1}, {31'b0, exp_q.size() > 0});
      chk("out_valid2", {31'b0, out_valid2}, {31'b0, exp_q.size() > 0});
      chk("beat_cnt1",  {16'b0, beat_cnt1},  32'(exp_cnt & 16'hFFFF));
      chk("beat_cnt2",  {28'b0, beat_cnt2},  32'(exp_cnt & 15));
      if (just_reset) begin
        chk("rst_out_data1", {16'b0, out_data1}, 32'h0);
        chk("rst_out_data2", {16'b0, out_data2}, 32'h0);
      end
    end
    just_reset = 0;
    if (RESET) begin
      exp_q.delete();
      exp2_q.delete();
      m_sa = '0; m_sb = '0; m_sel = '0; m_en = '0;
      exp_cnt = 0;
      model_ok = 1;
      just_reset = 1;
    end else if (model_ok) begin
      if (out_valid1 && OUT_READY) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'h1, 32'h0);
        end else begin
          chk("out_data1", {16'b0, out_data1}, {16'b0, exp_q.pop_front()});
          chk("out_data2", {16'b0, out_data2}, {16'b0, exp2_q.pop_front()});
        end
        exp_cnt++;
      end
      if (IN_VALID && in_ready1) begin
        exp_q.push_back(ref_sel(DATA_A, DATA_B, m_sa, m_sb, m_sel, m_en, 8));
        exp2_q.push_back(ref_sel(DATA_A & 32'h00FF_FFFF, DATA_B & 32'h00FF_FFFF,
                                 m_sa, m_sb, m_sel, m_en, 6));
      end
      if (CFG_WE) begin
        m_sa = CFG_SEL_A; m_sb = CFG_SEL_B; m_sel = CFG_SEL; m_en = CFG_LANE_EN;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_cfg(input logic [11:0] sa, input logic [11:0] sb,
                         input logic [3:0] sel, input logic [3:0] en);
    CFG_SEL_A = sa; CFG_SEL_B = sb; CFG_SEL = sel; CFG_LANE_EN = en;
    CFG_WE = 1'b1;
    next_cycle();
    CFG_WE = 1'b0;
  endtask

  // Offer one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic we);
    bit ok;
    int waited;
    DATA_A = a; DATA_B = b; IN_VALID = 1'b1; CFG_WE = we;
    waited = 0;
    ok = 0;
    while (!ok && waited < 40) begin
      @(negedge CLK);
      ok = in_ready1;
      next_cycle();
      CFG_WE = 1'b0;
      waited++;
    end
    IN_VALID = 1'b0;
    if (!ok) chk("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    next_cycle();
    RESET = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] third_a, third_b;
    RESET = 1'b1; CFG_WE = 1'b0; CFG_SEL_A = '0; CFG_SEL_B = '0;
    CFG_SEL = '0; CFG_LANE_EN = '0; IN_VALID = 1'b0;
    DATA_A = '0; DATA_B = '0; OUT_READY = 1'b0;
    repeat (2) next_cycle();
    RESET = 1'b0;

    // Basic select.
    OUT_READY = 1'b1;
    set_cfg(12'h001, 12'h688, 4'b0011, 4'hF);
    send_beat(32'h0000_0FFF, 32'h0000_ABCD, 1'b0);
    chk("t1_valid", {31'b0, out_valid1}, 32'h1);
    chk("t1_data",  {16'b0, out_data1},  32'h0000_FFCD);
    next_cycle();
    chk("t1_cnt",   {16'b0, beat_cnt1},  32'h1);

    // Backpressure: two fill the buffer, the third stalls.
    OUT_READY = 1'b0;
    send_beat($urandom, $urandom, 1'b0);
    send_beat($urandom, $urandom, 1'b0);
    third_a = $urandom; third_b = $urandom;
    DATA_A = third_a; DATA_B = third_b; IN_VALID = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("t2_stall", {31'b0, in_ready1}, 32'h0);
      next_cycle();
    end
    OUT_READY = 1'b1;
    send_beat(third_a, third_b, 1'b0);
    repeat (4) next_cycle();
    chk("t2_drained", {31'b0, out_valid1}, 32'h0);

    // Config change on the same edge a beat is accepted.
    set_cfg(12'h000, 12'h000, 4'b0000, 4'hF);
    CFG_SEL_A = 12'h053; CFG_SEL_B = 12'h2C4; CFG_SEL = 4'b1010; CFG_LANE_EN = 4'b1110;
    send_beat(32'hFEDC_BA98, 32'h7654_3210, 1'b1);
    send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("t3_lane0", {28'b0, out_data1[3:0]}, 32'h0);
    repeat (2) next_cycle();

    // Reset with two beats buffered.
    OUT_READY = 1'b0;
    send_beat($urandom, $urandom, 1'b0);
    send_beat($urandom, $urandom, 1'b0);
    pulse_reset();
    chk("t4_valid", {31'b0, out_valid1}, 32'h0);
    chk("t4_ready", {31'b0, in_ready1},  32'h1);
    chk("t4_cnt",   {16'b0, beat_cnt1},  32'h0);
    OUT_READY = 1'b1;
    send_beat(32'hFFFF_FFF0, $urandom, 1'b0);
    chk("t4_data",  {16'b0, out_data1},  32'h0);
    next_cycle();

    // Counter wrap at full throughput.
    pulse_reset();
    set_cfg(12'($urandom), 12'($urandom), 4'($urandom), 4'hF);
    IN_VALID = 1'b1;
    for (int i = 0; i < 17; i++) begin
      DATA_A = $urandom; DATA_B = $urandom;
      @(negedge CLK);
      chk("t5_in_ready", {31'b0, in_ready1}, 32'h1);
      next_cycle();
      if (i > 0) chk("t5_cnt2", {28'b0, beat_cnt2}, 32'(i % 16));
    end
    IN_VALID = 1'b0;
    next_cycle();
    chk("t5_cnt2_end", {28'b0, beat_cnt2}, 32'h1);
    chk("t5_cnt1_end", {16'b0, beat_cnt1}, 32'd17);

    // Index past the last lane on the six-lane instance.
    set_cfg({3'd0, 3'd7, 3'd1, 3'd2}, 12'h000, 4'b0000, 4'hF);
    send_beat(32'h9876_5432, 32'h0, 1'b0);
    chk("t6_lane2_w6", {28'b0, out_data2[11:8]}, 32'h0);
    chk("t6_lane2_w8", {28'b0, out_data1[11:8]}, 32'h9);
    next_cycle();

    // Randomised traffic with config writes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 3) != 0);
      DATA_A = $urandom; DATA_B = $urandom;
      CFG_WE = ($urandom_range(0, 15) == 0);
      CFG_SEL_A = 12'($urandom); CFG_SEL_B = 12'($urandom);
      CFG_SEL = 4'($urandom); CFG_LANE_EN = 4'($urandom);
      RESET = ($urandom_range(0, 149) == 0);
      next_cycle();
    end
    RESET = 1'b0; CFG_WE = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (4) next_cycle();
    chk("final_drain", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
